// File: rtl/reg_dest_file_pkg.sv
// Shared CPU definitions: register-select codes, register indices and default widths.
// Destination-select codes use the same values as the source-select codes.
package reg_dest_file_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 8;
    localparam int IDX_W      = 3;

    localparam logic [2:0] SEL_FIELD = 3'd0;
    localparam logic [2:0] SEL_R0    = 3'd1;
    localparam logic [2:0] SEL_R1    = 3'd2;
    localparam logic [2:0] SEL_R3    = 3'd3;
    localparam logic [2:0] SEL_R6    = 3'd4;
    localparam logic [2:0] SEL_R7    = 3'd5;
    localparam logic [2:0] SEL_R2    = 3'd6;
    localparam logic [2:0] SEL_NONE  = 3'd7;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_RUN  = 1'b1
    } dump_state_t;

endpackage

// File: rtl/reg_dest_decode.sv
// Destination-select decode: maps the 3-bit select code to a register index.
// Reusable by the hazard logic; wr_active is low only for the "no destination" code.
module reg_dest_decode
    import reg_dest_file_pkg::*;
(
    input  logic [2:0] wr_sel,
    input  logic [2:0] wr_field,
    output logic [2:0] wr_idx,
    output logic       wr_active
);

    always_comb begin
        wr_idx    = R0;
        wr_active = 1'b1;
        case (wr_sel)
            SEL_FIELD: wr_idx = wr_field;
            SEL_R0:    wr_idx = R0;
            SEL_R1:    wr_idx = R1;
            SEL_R3:    wr_idx = R3;
            SEL_R6:    wr_idx = R6;
            SEL_R7:    wr_idx = R7;
            SEL_R2:    wr_idx = R2;
            default:   wr_active = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_dest_file.sv
// Register file endpoint: decoded write port, two bypassed read ports and a
// sequential dump engine that streams every register out one per cycle.
//
// state     | meaning
// DUMP_IDLE | no dump in progress; dump outputs held at 0
// DUMP_RUN  | a dump beat is on the outputs; advance until index NREGS-1 is shown
module reg_dest_file
    import reg_dest_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_sel,
    input  logic [2:0]        wr_field,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [2:0]        wr_idx,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [2:0]        dump_idx,
    output logic [DATA_W-1:0] dump_data
);

    localparam logic [2:0] LAST_IDX = 3'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_active;
    logic              wr_go;

    dump_state_t       state, state_next;
    logic              valid_next;
    logic [2:0]        idx_next;
    logic [DATA_W-1:0] data_next;

    reg_dest_decode u_decode (
        .wr_sel    (wr_sel),
        .wr_field  (wr_field),
        .wr_idx    (wr_idx),
        .wr_active (wr_active)
    );

    assign wr_go = wr_en && wr_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_go) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data_a = (wr_go && (rd_addr_a == wr_idx)) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (wr_go && (rd_addr_b == wr_idx)) ? wr_data : regs[rd_addr_b];

    // The beat for index 0 is captured on the start edge, so the first valid
    // cycle is the one right after dump_start is sampled.
    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        idx_next   = 3'd0;
        data_next  = '0;
        case (state)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_next = DUMP_RUN;
                    valid_next = 1'b1;
                    idx_next   = 3'd0;
                    data_next  = regs[0];
                end
            end
            DUMP_RUN: begin
                if (dump_idx == LAST_IDX) begin
                    state_next = DUMP_IDLE;
                end else begin
                    valid_next = 1'b1;
                    idx_next   = dump_idx + 3'd1;
                    data_next  = regs[idx_next];
                end
            end
            default: state_next = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DUMP_IDLE;
            dump_valid <= 1'b0;
            dump_idx   <= 3'd0;
            dump_data  <= '0;
        end else begin
            state      <= state_next;
            dump_valid <= valid_next;
            dump_idx   <= idx_next;
            dump_data  <= data_next;
        end
    end

    assign dump_busy = (state == DUMP_RUN);

endmodule

// File: tb/tb_reg_dest_file.sv
// Self-checking bench for reg_dest_file: decode table, bypass, random traffic
// against an array model, and dump runs with writes and reset.
module tb_reg_dest_file;
    import reg_dest_file_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_sel = 3'd0;
    logic [2:0]    wr_field = 3'd0;
    logic [DW-1:0] wr_data = '0;
    logic [2:0]    rd_addr_a = 3'd0;
    logic [2:0]    rd_addr_b = 3'd0;
    logic          dump_start = 1'b0;
    logic [DW-1:0] rd_data_a, rd_data_b, dump_data;
    logic [2:0]    wr_idx, dump_idx;
    logic          dump_busy, dump_valid;

    reg_dest_file #(.DATA_W(DW), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_field(wr_field),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_idx(wr_idx),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_idx(dump_idx), .dump_data(dump_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model [8];
    // Destination register for each fixed select code (0 and 7 handled separately).
    logic [2:0] dest_tbl [8] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd6, 3'd7, 3'd2, 3'd0};

    typedef struct {
        logic [2:0]    sel;
        logic [2:0]    field;
        logic [DW-1:0] data;
        logic [2:0]    exp_idx;
        logic          exp_active;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] dest_of(input logic [2:0] sel, input logic [2:0] field);
        if (sel == 3'd0) return field;
        if (sel == 3'd7) return 3'd0;
        return dest_tbl[sel];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    task automatic step_write(input logic [2:0] sel, input logic [2:0] field, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_field = field; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel != 3'd7) model[dest_of(sel, field)] = data;
    endtask

    task automatic check_all(input string name);
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            chk({name, "_a"}, 32'(rd_data_a), 32'(model[i]));
            chk({name, "_b"}, 32'(rd_data_b), 32'(model[7 - i]));
        end
        @(negedge clk);
    endtask

    task automatic chk_dump_idle(input string name);
        chk({name, "_valid"}, 32'(dump_valid), 32'd0);
        chk({name, "_busy"}, 32'(dump_busy), 32'd0);
        chk({name, "_idx"}, 32'(dump_idx), 32'd0);
        chk({name, "_data"}, 32'(dump_data), 32'd0);
    endtask

    task automatic run_dump(input int restart_beat, input int wr_beat, input logic [2:0] wr_reg,
                            input logic [DW-1:0] wr_val, input int rst_beat);
        logic [DW-1:0] exp_next;
        dump_start = 1'b1;
        exp_next = model[0];
        @(negedge clk);
        dump_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("dump_valid", 32'(dump_valid), 32'd1);
            chk("dump_busy", 32'(dump_busy), 32'd1);
            chk("dump_idx", 32'(dump_idx), 32'(k));
            chk("dump_data", 32'(dump_data), 32'(exp_next));
            if (k == rst_beat) begin
                #1 rst_n = 1'b0;
                rd_addr_a = 3'd4; rd_addr_b = 3'd0;
                #1;
                chk_dump_idle("dump_rst");
                chk("dump_rst_rd_a", 32'(rd_data_a), 32'd0);
                chk("dump_rst_rd_b", 32'(rd_data_b), 32'd0);
                clear_model();
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk); #1;
                    chk_dump_idle("dump_after_rst");
                end
                @(negedge clk);
                return;
            end
            // The next beat samples its register on the same edge that commits any write here.
            if (k < 7) exp_next = model[k + 1];
            dump_start = (k == restart_beat);
            if (k == wr_beat) begin
                wr_en = 1'b1; wr_sel = SEL_FIELD; wr_field = wr_reg; wr_data = wr_val;
                model[wr_reg] = wr_val;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0; dump_start = 1'b0;
        #1;
        chk("dump_end_valid", 32'(dump_valid), 32'd0);
        chk("dump_end_busy", 32'(dump_busy), 32'd0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("dump_quiet_valid", 32'(dump_valid), 32'd0);
            chk("dump_quiet_busy", 32'(dump_busy), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{SEL_R6,    3'd0, 16'hBEEF, 3'd6, 1'b1};
        vecs[1] = '{SEL_R0,    3'd4, 16'h1111, 3'd0, 1'b1};
        vecs[2] = '{SEL_R1,    3'd4, 16'h2222, 3'd1, 1'b1};
        vecs[3] = '{SEL_R3,    3'd4, 16'h3333, 3'd3, 1'b1};
        vecs[4] = '{SEL_R7,    3'd4, 16'h7777, 3'd7, 1'b1};
        vecs[5] = '{SEL_R2,    3'd4, 16'h2AAA, 3'd2, 1'b1};
        vecs[6] = '{SEL_FIELD, 3'd5, 16'h00A5, 3'd5, 1'b1};
        vecs[7] = '{SEL_NONE,  3'd5, 16'hFFFF, 3'd0, 1'b0};
        clear_model();

        #12;
        chk_dump_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset_rd");

        for (int v = 0; v < 8; v++) begin
            wr_en = 1'b1; wr_sel = vecs[v].sel; wr_field = vecs[v].field; wr_data = vecs[v].data;
            rd_addr_a = vecs[v].exp_idx; rd_addr_b = vecs[v].exp_idx ^ 3'd1;
            #1;
            chk("decode_idx", 32'(wr_idx), 32'(vecs[v].exp_idx));
            chk("decode_bypass_a", 32'(rd_data_a),
                vecs[v].exp_active ? 32'(vecs[v].data) : 32'(model[vecs[v].exp_idx]));
            chk("decode_other_b", 32'(rd_data_b), 32'(model[vecs[v].exp_idx ^ 3'd1]));
            @(negedge clk);
            wr_en = 1'b0;
            if (vecs[v].exp_active) model[vecs[v].exp_idx] = vecs[v].data;
            #1;
            chk("decode_stored", 32'(rd_data_a), 32'(model[vecs[v].exp_idx]));
            check_all("decode_scan");
        end

        step_write(SEL_R3, 3'd0, 16'h0011);
        wr_en = 1'b1; wr_sel = SEL_R3; wr_data = 16'h0022; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        #1;
        chk("bypass_a", 32'(rd_data_a), 32'h0022);
        chk("bypass_b", 32'(rd_data_b), 32'h0022);
        @(negedge clk);
        wr_en = 1'b0;
        model[3] = 16'h0022;
        #1;
        chk("bypass_stored", 32'(rd_data_a), 32'h0022);
        @(negedge clk);

        for (int i = 0; i < 8; i++) step_write(SEL_FIELD, 3'(i), 16'h1234);
        #2 rst_n = 1'b0;
        clear_model();
        check_all("async_reset_rd");
        chk_dump_idle("async_reset_dump");
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            logic [2:0] d;
            wr_en = 1'($urandom_range(0, 1));
            wr_sel = 3'($urandom_range(0, 7));
            wr_field = 3'($urandom_range(0, 7));
            wr_data = 16'($urandom);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = 3'($urandom_range(0, 7));
            d = dest_of(wr_sel, wr_field);
            #1;
            chk("rand_idx", 32'(wr_idx), 32'(d));
            chk("rand_rd_a", 32'(rd_data_a),
                (wr_en && wr_sel != 3'd7 && rd_addr_a == d) ? 32'(wr_data) : 32'(model[rd_addr_a]));
            chk("rand_rd_b", 32'(rd_data_b),
                (wr_en && wr_sel != 3'd7 && rd_addr_b == d) ? 32'(wr_data) : 32'(model[rd_addr_b]));
            @(negedge clk);
            if (wr_en && wr_sel != 3'd7) model[d] = wr_data;
        end
        wr_en = 1'b0;
        check_all("rand_final");

        for (int i = 0; i < 8; i++) step_write(SEL_FIELD, 3'(i), 16'(16'h0100 + i));
        run_dump(3, -1, 3'd0, 16'h0000, -1);
        run_dump(-1, 2, 3'd6, 16'h0BAD, -1);
        run_dump(-1, 2, 3'd3, 16'h0C33, -1);
        check_all("after_dumps");
        run_dump(-1, -1, 3'd0, 16'h0000, 4);
        check_all("after_dump_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
